vai_tx_req_buffer: RTL and testbench

Per-sub-AFU Tx request buffer between each sub-AFU's Tx channel and the corresponding `afu_TxPort` input of `vai_mux`. It absorbs requests the sub-AFU issues after almost-full is raised and meters them out only while the mux reports room. It gives each sub-AFU an early, locally computed almost-full indication with guaranteed slack, so a slow-reacting sub-AFU can never overrun the mux. One instance is placed per channel (c0 read, c1 write) per sub-AFU.

---
 rtl/vai_pkg.sv | 23 ++
 rtl/vai_txbuf_ram.sv | 24 ++
 rtl/vai_tx_req_buffer.sv | 103 ++++++++++
 tb/tb_vai_tx_req_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vai_pkg.sv
// Shared VAI definitions: Tx buffer sizing defaults and CCI-P Tx payload widths.
package vai_pkg;

  localparam int unsigned VAI_TXBUF_DEPTH = 8;
  localparam int unsigned VAI_TXBUF_SLACK = 4;

  typedef logic [$clog2(VAI_TXBUF_DEPTH):0] t_vai_txbuf_cnt;

  // Header sizes mirror ccip_if_pkg (c0 ReqMemHdr, c1 ReqMemHdr, cache line).
  localparam int unsigned CCIP_C0TX_HDR_W = 74;
  localparam int unsigned CCIP_C1TX_HDR_W = 80;
  localparam int unsigned CCIP_CLDATA_W   = 512;

  localparam int unsigned VAI_C0TX_PAYLOAD_W = CCIP_C0TX_HDR_W;
  localparam int unsigned VAI_C1TX_PAYLOAD_W = CCIP_C1TX_HDR_W + CCIP_CLDATA_W;

  // Occupancy at which the sub-AFU is told to stop issuing.
  function automatic int unsigned vai_txbuf_almfull_thr(input int unsigned depth,
                                                        input int unsigned slack);
    return depth - slack;
  endfunction

endpackage

// File: rtl/vai_txbuf_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read (MLAB-friendly).
module vai_txbuf_ram #(
  parameter int unsigned DATA_W = 592,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset on the array so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vai_tx_req_buffer.sv
// Per-sub-AFU Tx request buffer: absorbs post-almfull requests and meters them to vai_mux.
module vai_tx_req_buffer
  import vai_pkg::*;
#(
  parameter int unsigned DATA_W        = VAI_C1TX_PAYLOAD_W,
  parameter int unsigned DEPTH         = VAI_TXBUF_DEPTH,
  parameter int unsigned ALMFULL_SLACK = VAI_TXBUF_SLACK
) (
  input  logic                     pClk,
  input  logic                     SoftReset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_almfull,
  input  logic                     up_almfull,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow
);

  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned ALMFULL_THR = vai_txbuf_almfull_thr(DEPTH, ALMFULL_SLACK);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head_data;

  vai_txbuf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (pClk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  // Pop needs only room upstream; a push at full is legal when it coincides with a pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_d       = err_q;

    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    pop   = !empty && !up_almfull;
    push  = in_valid && (!full || pop);

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = head_data;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (in_valid && !push) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign in_almfull   = (count_q >= CNT_W'(ALMFULL_THR));
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign count        = count_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_vai_tx_req_buffer.sv
// Bench for vai_tx_req_buffer: directed vector table, async-reset sequence, randomized queue-model run.
module tb_vai_tx_req_buffer;

  localparam int unsigned DATA_W = 592;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SLACK  = 4;
  localparam int unsigned CNT_W  = 4;

  logic              pClk = 1'b0;
  logic              SoftReset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_almfull;
  logic              up_almfull = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              err_overflow;

  always #5 pClk = ~pClk;

  vai_tx_req_buffer #(
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (SLACK)
  ) dut (
    .pClk         (pClk),
    .SoftReset_n  (SoftReset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_almfull   (in_almfull),
    .up_almfull   (up_almfull),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .count        (count),
    .err_overflow (err_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs change one time unit after the edge; outputs are sampled at the same point.
  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic up);
    in_valid   = iv;
    in_data    = d;
    up_almfull = up;
    @(posedge pClk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rst out_valid"}, DATA_W'(out_valid), '0);
    chk({tag, " rst out_data"}, out_data, '0);
    chk({tag, " rst count"}, DATA_W'(count), '0);
    chk({tag, " rst in_almfull"}, DATA_W'(in_almfull), '0);
    chk({tag, " rst err"}, DATA_W'(err_overflow), '0);
  endtask

  // Reference: FIFO as a queue, outputs as last popped element.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_od;
  logic              m_ov;
  logic              m_err;

  task automatic model_clear();
    mq.delete();
    m_od  = '0;
    m_ov  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [DATA_W-1:0] d, input logic up);
    bit pop, push;
    pop  = (mq.size() > 0) && !up;
    push = iv && ((mq.size() < DEPTH) || pop);
    m_ov = pop;
    if (pop) m_od = mq.pop_front();
    if (push) mq.push_back(d);
    else if (iv) m_err = 1'b1;
  endtask

  task automatic cycle(input string tag, input logic iv, input logic [DATA_W-1:0] d, input logic up);
    model_step(iv, d, up);
    drive(iv, d, up);
    chk({tag, " count"}, DATA_W'(count), DATA_W'(mq.size()));
    chk({tag, " out_valid"}, DATA_W'(out_valid), DATA_W'(m_ov));
    chk({tag, " out_data"}, out_data, m_od);
    chk({tag, " in_almfull"}, DATA_W'(in_almfull), DATA_W'(mq.size() >= DEPTH - SLACK));
    chk({tag, " err"}, DATA_W'(err_overflow), DATA_W'(m_err));
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int w = 0; w < (DATA_W + 31) / 32; w++) r = {r[DATA_W-33:0], 32'($urandom)};
    return r;
  endfunction

  typedef struct {
    bit       rst;
    bit       iv;
    bit [7:0] d;
    bit       up;
    int       cnt;
    bit       ov;
    bit [7:0] od;
    bit       alm;
    bit       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit iv, int d, bit up, int cnt, bit ov, int od, bit alm, bit err);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = 8'(d); v.up = up; v.cnt = cnt;
    v.ov = ov; v.od = 8'(od); v.alm = alm; v.err = err;
    return v;
  endfunction

  initial begin
    // Single push: visible two edges later, count 0->1->0.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'hA5, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hA5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'hA5, 0, 0));
    // Back-to-back 1..16 streams straight through.
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(0, 1, k, 0, 1, k > 1, (k > 1) ? k - 1 : 'hA5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16, 0, 0));
    // Held off upstream: fill to 8, then overflow on 9, then drain 1..8.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, k, 1, k, 0, 16, k >= 4, 0));
    vecs.push_back(mk(0, 1, 9, 1, 8, 0, 16, 1, 1));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(0, 0, 0, 0, 8 - j, 1, j, (8 - j) >= 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8, 0, 1));
    // Full with simultaneous push and pop: no overflow, order 1..9.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, k, 1, k, 0, 0, k >= 4, 0));
    vecs.push_back(mk(0, 1, 9, 0, 8, 1, 1, 1, 0));
    for (int j = 2; j <= 9; j++)
      vecs.push_back(mk(0, 0, 0, 0, 9 - j, 1, j, (9 - j) >= 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 0));

    #12;
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].rst) begin
        #2;
        SoftReset_n = 1'b0;
        in_valid    = 1'b0;
        up_almfull  = 1'b0;
        #1;
        chk_zero(tag);
        @(posedge pClk);
        #1;
        SoftReset_n = 1'b1;
      end else begin
        drive(vecs[i].iv, DATA_W'(vecs[i].d), vecs[i].up);
        chk({tag, " count"}, DATA_W'(count), DATA_W'(vecs[i].cnt));
        chk({tag, " out_valid"}, DATA_W'(out_valid), DATA_W'(vecs[i].ov));
        chk({tag, " out_data"}, out_data, DATA_W'(vecs[i].od));
        chk({tag, " in_almfull"}, DATA_W'(in_almfull), DATA_W'(vecs[i].alm));
        chk({tag, " err"}, DATA_W'(err_overflow), DATA_W'(vecs[i].err));
      end
    end

    // Async reset mid-burst at count 5 with output active and overflow set.
    #2;
    SoftReset_n = 1'b0;
    #1;
    @(posedge pClk);
    #1;
    SoftReset_n = 1'b1;
    model_clear();
    for (int k = 1; k <= 8; k++) cycle("arst fill", 1'b1, DATA_W'(k), 1'b1);
    cycle("arst ovf", 1'b1, DATA_W'(9), 1'b1);
    for (int k = 0; k < 3; k++) cycle("arst drain", 1'b0, '0, 1'b0);
    chk("arst pre count", DATA_W'(count), DATA_W'(5));
    #2;
    SoftReset_n = 1'b0;
    in_valid    = 1'b0;
    #1;
    chk_zero("arst");
    @(negedge pClk);
    SoftReset_n = 1'b1;
    model_clear();
    in_valid   = 1'b1;
    in_data    = DATA_W'('h77);
    up_almfull = 1'b0;
    @(posedge pClk);
    #1;
    model_step(1'b1, DATA_W'('h77), 1'b0);
    chk("arst first count", DATA_W'(count), DATA_W'(1));
    chk("arst first ov", DATA_W'(out_valid), '0);
    cycle("arst out", 1'b0, '0, 1'b0);
    chk("arst out data", out_data, DATA_W'('h77));
    cycle("arst idle", 1'b0, '0, 1'b0);

    // Randomized run against the queue model, alternating light and heavy upstream pressure.
    for (int i = 0; i < 3000; i++) begin
      logic iv, up;
      iv = ($urandom_range(0, 9) < 7);
      if (((i / 150) % 2) == 1) up = ($urandom_range(0, 9) < 8);
      else                      up = ($urandom_range(0, 9) < 2);
      cycle($sformatf("rnd%0d", i), iv, rand_data(), up);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
